// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: access-size codes,
// FSM state encoding and the word-index width helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {IDLE, LD, RD, WR, DONE} state_t;

  // Word-index width for a memory of `depth` words (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational lane steering: extracts/extends load data from a memory
// word and merges sub-word store data into an old word (little-endian lanes).
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: pick the addressed lane, then sign/zero extend.
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sgn & half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase
  end

  // Store path: overwrite only the addressed lane of the old word.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = new_data[7:0];
          2'd1:    merged[15:8]  = new_data[7:0];
          2'd2:    merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = new_data[15:0];
        else         merged[15:0]  = new_data[15:0];
      end
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between core and word-wide data memory. One request
// at a time: IDLE -> LD | RD -> WR | WR | DONE(error) -> DONE -> IDLE.
// Optional macro LSU_ALIGN_CHECK_EN: when defined, misaligned, reserved-size
// and out-of-range requests are rejected with ErrOut; when undefined they are
// aligned down / treated as word / wrapped modulo DEPTH and ErrOut stays 0.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        ReqIn,
  input  logic        WeIn,
  input  logic [1:0]  SizeIn,
  input  logic        SignedIn,
  input  logic [31:0] AddrIn,
  input  logic [31:0] WDataIn,
  output logic        ReqReadyOut,
  output logic        DoneOut,
  output logic        ErrOut,
  output logic [31:0] LoadDataOut,
  output logic [31:0] MemAddrOut,
  output logic [31:0] MemDataOut,
  output logic        MemReadOut,
  output logic        MemWriteOut,
  input  logic [31:0] MemDataIn
);

  state_t      state, state_nxt;
  logic [1:0]  lane_q, size_q;
  logic        sgn_q, err_q;
  logic [31:0] wdata_q;

  logic [29:0]      waddr;
  logic [1:0]       size_n, lane_n;
  logic [IDX_W-1:0] idx_n;
  logic             err_n;
  logic [31:0]      load_data, merged;

  assign waddr = AddrIn[31:2];

  // Decode the incoming request: effective size, lane, word index, error.
  always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
    size_n = SizeIn;
    lane_n = AddrIn[1:0];
    idx_n  = AddrIn[IDX_W+1:2];
    err_n  = (SizeIn == SZ_HALF && AddrIn[0]) ||
             (SizeIn == SZ_WORD && AddrIn[1:0] != 2'b00) ||
             (SizeIn == SZ_RSVD) ||
             ({2'b00, waddr} >= 32'(DEPTH));
`else
    size_n = (SizeIn == SZ_RSVD) ? SZ_WORD : SizeIn;
    lane_n = AddrIn[1:0];
    if (size_n == SZ_HALF) lane_n[0] = 1'b0;
    if (size_n == SZ_WORD) lane_n    = 2'b00;
    idx_n  = IDX_W'(waddr % 30'(DEPTH));
    err_n  = 1'b0;
`endif
  end

  lsu_lane_mux u_lane_mux (
    .word      (MemDataIn),
    .lane      (lane_q),
    .size      (size_q),
    .sgn       (sgn_q),
    .new_data  (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Next-state and strobes; memory strobes are gated by reset so a write
  // caught mid-flight by reset never reaches the memory.
  always_comb begin
    state_nxt   = state;
    ReqReadyOut = (state == IDLE);
    DoneOut     = (state == DONE);
    ErrOut      = (state == DONE) && err_q;
    MemReadOut  = !resetIn && (state == LD || state == RD);
    MemWriteOut = !resetIn && (state == WR);
    case (state)
      IDLE: if (ReqIn) begin
        if (err_n)                 state_nxt = DONE;
        else if (!WeIn)            state_nxt = LD;
        else if (size_n == SZ_WORD) state_nxt = WR;
        else                       state_nxt = RD;
      end
      LD:      state_nxt = DONE;
      RD:      state_nxt = WR;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus request capture, load result and write-data staging.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state       <= IDLE;
      lane_q      <= 2'b00;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      LoadDataOut <= '0;
      MemAddrOut  <= '0;
      MemDataOut  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && ReqIn) begin
        lane_q  <= lane_n;
        size_q  <= size_n;
        sgn_q   <= SignedIn;
        err_q   <= err_n;
        wdata_q <= WDataIn;
        if (!err_n) MemAddrOut <= 32'(idx_n);
        if (!err_n && WeIn && size_n == SZ_WORD) MemDataOut <= WDataIn;
      end
      if (state == LD) LoadDataOut <= load_data;
      if (state == RD) MemDataOut  <= merged;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small combinational-read memory model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int DEPTH = 32;

  logic        clkIn = 1'b0;
  logic        resetIn, ReqIn, WeIn, SignedIn;
  logic [1:0]  SizeIn;
  logic [31:0] AddrIn, WDataIn;
  logic        ReqReadyOut, DoneOut, ErrOut, MemReadOut, MemWriteOut;
  logic [31:0] LoadDataOut, MemAddrOut, MemDataOut, MemDataIn;

  logic [31:0] mem [DEPTH];
  int n_chk = 0;
  int n_err = 0;

  int          lat, wr_lat;
  logic        err, rd_seen, wr_seen;
  logic [31:0] wr_addr;

  lsu_ctrl #(.DEPTH(DEPTH)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .ReqIn(ReqIn), .WeIn(WeIn),
    .SizeIn(SizeIn), .SignedIn(SignedIn), .AddrIn(AddrIn), .WDataIn(WDataIn),
    .ReqReadyOut(ReqReadyOut), .DoneOut(DoneOut), .ErrOut(ErrOut),
    .LoadDataOut(LoadDataOut), .MemAddrOut(MemAddrOut), .MemDataOut(MemDataOut),
    .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut), .MemDataIn(MemDataIn)
  );

  always #5 clkIn = ~clkIn;

  // memory model: contents survive resetIn so suppressed writes are visible
  assign MemDataIn = mem[MemAddrOut[4:0]];
  always @(posedge clkIn) if (MemWriteOut) mem[MemAddrOut[4:0]] <= MemDataOut;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to DoneOut, recording latency and strobes.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    int guard;
    guard = 0;
    while (!ReqReadyOut && guard < 10) begin @(posedge clkIn); #1; guard++; end
    ReqIn = 1'b1; WeIn = we; SizeIn = sz; SignedIn = sg; AddrIn = a; WDataIn = wd;
    @(posedge clkIn); #1;
    ReqIn = 1'b0;
    lat = 0; wr_lat = 0; err = 1'b0; rd_seen = 1'b0; wr_seen = 1'b0; wr_addr = '0;
    while (1) begin
      lat++;
      if (MemReadOut) rd_seen = 1'b1;
      if (MemWriteOut) begin wr_seen = 1'b1; wr_addr = MemAddrOut; wr_lat = lat; end
      if (DoneOut) begin err = ErrOut; break; end
      if (lat >= 16) begin chk("done_timeout", {31'b0, DoneOut}, 32'd1); break; end
      @(posedge clkIn); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetIn = 1'b1; ReqIn = 1'b0; WeIn = 1'b0; SizeIn = SZ_BYTE; SignedIn = 1'b0;
    AddrIn = '0; WDataIn = '0;
    repeat (2) @(posedge clkIn);
    #1;
    chk("rst_memread",  {31'b0, MemReadOut},  32'd0);
    chk("rst_memwrite", {31'b0, MemWriteOut}, 32'd0);
    resetIn = 1'b0;
    chk("rst_ready",   {31'b0, ReqReadyOut}, 32'd1);
    chk("rst_done",    {31'b0, DoneOut},     32'd0);
    chk("rst_err",     {31'b0, ErrOut},      32'd0);
    chk("rst_ldata",   LoadDataOut, 32'd0);
    chk("rst_maddr",   MemAddrOut,  32'd0);
    chk("rst_mdata",   MemDataOut,  32'd0);

    // 1: word store then word load
    run_req(1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEADBEEF);
    chk("t1_lat",     lat, 2);
    chk("t1_wr_lat",  wr_lat, 1);
    chk("t1_wr_addr", wr_addr, 32'd2);
    chk("t1_err",     {31'b0, err}, 32'd0);
    chk("t1_mem",     mem[2], 32'hDEADBEEF);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0);
    chk("t1_ld",      LoadDataOut, 32'hDEADBEEF);
    chk("t1_ld_lat",  lat, 2);
    chk("t1_ld_rd",   {31'b0, rd_seen}, 32'd1);
    @(posedge clkIn); #1;
    chk("b2b_ready",  {31'b0, ReqReadyOut}, 32'd1);

    // preload through the DUT
    run_req(1'b1, SZ_WORD, 1'b0, 32'h04, 32'h11223344);
    run_req(1'b1, SZ_WORD, 1'b0, 32'h00, 32'hCAFEF00D);
    run_req(1'b1, SZ_WORD, 1'b0, 32'h0C, 32'h55667788);
    chk("pre_mem1", mem[1], 32'h11223344);

    // 2: byte store read-modify-write
    run_req(1'b1, SZ_BYTE, 1'b0, 32'h05, 32'h123456AB);
    chk("t2_lat",    lat, 3);
    chk("t2_rd",     {31'b0, rd_seen}, 32'd1);
    chk("t2_wr_lat", wr_lat, 2);
    chk("t2_mem",    mem[1], 32'h1122AB44);

    // 3: extending loads
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h05, 32'h0);
    chk("t3_lb_s",  LoadDataOut, 32'hFFFFFFAB);
    run_req(1'b0, SZ_BYTE, 1'b0, 32'h05, 32'h0);
    chk("t3_lb_u",  LoadDataOut, 32'h000000AB);
    run_req(1'b0, SZ_HALF, 1'b1, 32'h06, 32'h0);
    chk("t3_lh6_s", LoadDataOut, 32'h00001122);
    run_req(1'b0, SZ_HALF, 1'b1, 32'h04, 32'h0);
    chk("t3_lh4_s", LoadDataOut, 32'hFFFFAB44);
    run_req(1'b0, SZ_HALF, 1'b0, 32'h04, 32'h0);
    chk("t3_lh4_u", LoadDataOut, 32'h0000AB44);
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h07, 32'h0);
    chk("t3_lb7_s", LoadDataOut, 32'h00000011);

    // 4: misaligned halfword store, reserved size load
    run_req(1'b1, SZ_HALF, 1'b0, 32'h01, 32'h00005A5A);
`ifdef LSU_ALIGN_CHECK_EN
    chk("t4_lat",  lat, 1);
    chk("t4_err",  {31'b0, err}, 32'd1);
    chk("t4_strb", {30'b0, rd_seen, wr_seen}, 32'd0);
    chk("t4_mem",  mem[0], 32'hCAFEF00D);
    run_req(1'b0, SZ_RSVD, 1'b0, 32'h08, 32'h0);
    chk("t4_rsvd_err", {31'b0, err}, 32'd1);
    chk("t4_rsvd_lat", lat, 1);
`else
    chk("t4_lat",  lat, 3);
    chk("t4_err",  {31'b0, err}, 32'd0);
    chk("t4_mem",  mem[0], 32'hCAFE5A5A);
    run_req(1'b0, SZ_RSVD, 1'b0, 32'h08, 32'h0);
    chk("t4_rsvd_err", {31'b0, err}, 32'd0);
    chk("t4_rsvd_ld",  LoadDataOut, 32'hDEADBEEF);
`endif

    // 5: request while busy is ignored; reset during WR suppresses the write
    while (!ReqReadyOut) begin @(posedge clkIn); #1; end
    ReqIn = 1'b1; WeIn = 1'b1; SizeIn = SZ_BYTE; SignedIn = 1'b0;
    AddrIn = 32'h0C; WDataIn = 32'h000000EE;
    @(posedge clkIn); #1;
    SizeIn = SZ_WORD; AddrIn = 32'h08; WDataIn = 32'h99999999;
    chk("t5_rd_ready", {31'b0, ReqReadyOut}, 32'd0);
    chk("t5_rd_read",  {31'b0, MemReadOut},  32'd1);
    @(posedge clkIn); #1;
    ReqIn = 1'b0;
    chk("t5_wr_write", {31'b0, MemWriteOut}, 32'd1);
    resetIn = 1'b1;
    #1;
    chk("t5_rst_gate", {31'b0, MemWriteOut}, 32'd0);
    @(posedge clkIn); #1;
    resetIn = 1'b0;
    chk("t5_ready", {31'b0, ReqReadyOut}, 32'd1);
    chk("t5_done",  {31'b0, DoneOut},     32'd0);
    chk("t5_maddr", MemAddrOut,  32'd0);
    chk("t5_mdata", MemDataOut,  32'd0);
    chk("t5_ldata", LoadDataOut, 32'd0);
    chk("t5_mem3",  mem[3], 32'h55667788);
    @(posedge clkIn); #1;
    chk("t5_ready2", {31'b0, ReqReadyOut}, 32'd1);
    chk("t5_mem2",   mem[2], 32'hDEADBEEF);

    // 6: out-of-range word load
    run_req(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0);
    chk("t6_pre", LoadDataOut, 32'hDEADBEEF);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("t6_err", {31'b0, err}, 32'd1);
    chk("t6_lat", lat, 1);
    chk("t6_rd",  {31'b0, rd_seen}, 32'd0);
    chk("t6_ld",  LoadDataOut, 32'hDEADBEEF);
`else
    chk("t6_err", {31'b0, err}, 32'd0);
    chk("t6_lat", lat, 2);
    chk("t6_ld",  LoadDataOut, 32'hCAFE5A5A);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
